// File: rtl/core.sv
// Single-cycle RV64I integer core: one instruction fetched, executed and retired per clock.
// Loads, stores, fences, system and unrecognised encodings retire as pc+4 no-ops.
module core #(
    parameter int                    ARCH_WIDTH   = 64,
    parameter int                    ALU_OP_WIDTH = 4,
    parameter logic [ARCH_WIDTH-1:0] RESET_PC     = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ARCH_WIDTH-1:0] pc,
    input  logic [31:0]           instruction,
    input  logic [4:0]            dbg_reg_addr,
    output logic [ARCH_WIDTH-1:0] dbg_reg_data
);

    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;

    typedef enum logic [ALU_OP_WIDTH-1:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,  ALU_AND
    } alu_op_t;

    typedef enum logic [1:0] {RES_ALU, RES_LINK, RES_LUI, RES_AUIPC} res_sel_t;

    logic [ARCH_WIDTH-1:0] r_pc;
    logic [ARCH_WIDTH-1:0] r_regs [0:31];

    logic [6:0]            w_opcode;
    logic [4:0]            w_rd, w_rs1, w_rs2;
    logic [2:0]            w_funct3;
    logic [6:0]            w_funct7;
    logic [ARCH_WIDTH-1:0] w_rs1_val, w_rs2_val;
    logic [ARCH_WIDTH-1:0] w_imm_i, w_imm_b, w_imm_u, w_imm_j;
    logic [ARCH_WIDTH-1:0] w_pc_plus4, w_next_pc, w_wr_data;
    logic [ARCH_WIDTH-1:0] w_alu_a, w_alu_b, w_alu_raw, w_alu_res;
    logic [5:0]            w_shamt;
    alu_op_t               w_alu_op;
    res_sel_t              w_res_sel;
    logic                  w_src_imm, w_is_w, w_we, w_br_taken;

    assign w_opcode = instruction[6:0];
    assign w_rd     = instruction[11:7];
    assign w_funct3 = instruction[14:12];
    assign w_rs1    = instruction[19:15];
    assign w_rs2    = instruction[24:20];
    assign w_funct7 = instruction[31:25];

    assign w_imm_i = {{(ARCH_WIDTH-12){instruction[31]}}, instruction[31:20]};
    assign w_imm_b = {{(ARCH_WIDTH-13){instruction[31]}}, instruction[31], instruction[7],
                      instruction[30:25], instruction[11:8], 1'b0};
    assign w_imm_u = {{(ARCH_WIDTH-32){instruction[31]}}, instruction[31:12], 12'b0};
    assign w_imm_j = {{(ARCH_WIDTH-21){instruction[31]}}, instruction[31], instruction[19:12],
                      instruction[20], instruction[30:21], 1'b0};

    // x0 is never written, but the explicit zero keeps reads independent of that.
    assign w_rs1_val    = (w_rs1 == 5'd0) ? '0 : r_regs[w_rs1];
    assign w_rs2_val    = (w_rs2 == 5'd0) ? '0 : r_regs[w_rs2];
    assign dbg_reg_data = (dbg_reg_addr == 5'd0) ? '0 : r_regs[dbg_reg_addr];

    assign pc         = r_pc;
    assign w_pc_plus4 = r_pc + ARCH_WIDTH'(4);

    always_comb begin
        case (w_funct3)
            3'd0:    w_br_taken = (w_rs1_val == w_rs2_val);
            3'd1:    w_br_taken = (w_rs1_val != w_rs2_val);
            3'd4:    w_br_taken = ($signed(w_rs1_val) <  $signed(w_rs2_val));
            3'd5:    w_br_taken = ($signed(w_rs1_val) >= $signed(w_rs2_val));
            3'd6:    w_br_taken = (w_rs1_val <  w_rs2_val);
            3'd7:    w_br_taken = (w_rs1_val >= w_rs2_val);
            default: w_br_taken = 1'b0;
        endcase
    end

    always_comb begin
        w_alu_op  = ALU_ADD;
        w_res_sel = RES_ALU;
        w_src_imm = 1'b0;
        w_is_w    = 1'b0;
        w_we      = 1'b0;
        w_next_pc = w_pc_plus4;
        case (w_opcode)
            OPC_LUI: begin
                w_we      = 1'b1;
                w_res_sel = RES_LUI;
            end
            OPC_AUIPC: begin
                w_we      = 1'b1;
                w_res_sel = RES_AUIPC;
            end
            OPC_JAL: begin
                w_we      = 1'b1;
                w_res_sel = RES_LINK;
                w_next_pc = r_pc + w_imm_j;
            end
            OPC_JALR: begin
                if (w_funct3 == 3'd0) begin
                    w_we      = 1'b1;
                    w_res_sel = RES_LINK;
                    w_next_pc = (w_rs1_val + w_imm_i) & ~ARCH_WIDTH'(1);
                end
            end
            OPC_BRANCH: begin
                if (w_br_taken) w_next_pc = r_pc + w_imm_b;
            end
            OPC_OP_IMM: begin
                w_src_imm = 1'b1;
                w_we      = 1'b1;
                case (w_funct3)
                    3'd0: w_alu_op = ALU_ADD;
                    3'd2: w_alu_op = ALU_SLT;
                    3'd3: w_alu_op = ALU_SLTU;
                    3'd4: w_alu_op = ALU_XOR;
                    3'd6: w_alu_op = ALU_OR;
                    3'd7: w_alu_op = ALU_AND;
                    3'd1: begin
                        w_alu_op = ALU_SLL;
                        w_we     = (w_funct7[6:1] == 6'b000000);
                    end
                    default: begin
                        w_alu_op = w_funct7[5] ? ALU_SRA : ALU_SRL;
                        w_we     = (w_funct7[6:1] == 6'b000000) || (w_funct7[6:1] == 6'b010000);
                    end
                endcase
            end
            OPC_OP: begin
                w_we = 1'b1;
                case ({w_funct7, w_funct3})
                    {7'h00, 3'd0}: w_alu_op = ALU_ADD;
                    {7'h20, 3'd0}: w_alu_op = ALU_SUB;
                    {7'h00, 3'd1}: w_alu_op = ALU_SLL;
                    {7'h00, 3'd2}: w_alu_op = ALU_SLT;
                    {7'h00, 3'd3}: w_alu_op = ALU_SLTU;
                    {7'h00, 3'd4}: w_alu_op = ALU_XOR;
                    {7'h00, 3'd5}: w_alu_op = ALU_SRL;
                    {7'h20, 3'd5}: w_alu_op = ALU_SRA;
                    {7'h00, 3'd6}: w_alu_op = ALU_OR;
                    {7'h00, 3'd7}: w_alu_op = ALU_AND;
                    default:       w_we     = 1'b0;
                endcase
            end
            OPC_OP_IMM_32: begin
                w_src_imm = 1'b1;
                w_is_w    = 1'b1;
                w_we      = 1'b1;
                case ({w_funct7, w_funct3})
                    {7'h00, 3'd1}: w_alu_op = ALU_SLL;
                    {7'h00, 3'd5}: w_alu_op = ALU_SRL;
                    {7'h20, 3'd5}: w_alu_op = ALU_SRA;
                    default: begin
                        w_alu_op = ALU_ADD;
                        w_we     = (w_funct3 == 3'd0);
                    end
                endcase
            end
            OPC_OP_32: begin
                w_is_w = 1'b1;
                w_we   = 1'b1;
                case ({w_funct7, w_funct3})
                    {7'h00, 3'd0}: w_alu_op = ALU_ADD;
                    {7'h20, 3'd0}: w_alu_op = ALU_SUB;
                    {7'h00, 3'd1}: w_alu_op = ALU_SLL;
                    {7'h00, 3'd5}: w_alu_op = ALU_SRL;
                    {7'h20, 3'd5}: w_alu_op = ALU_SRA;
                    default:       w_we     = 1'b0;
                endcase
            end
            default: ;
        endcase
    end

    assign w_alu_a = w_rs1_val;
    assign w_alu_b = w_src_imm ? w_imm_i : w_rs2_val;
    assign w_shamt = w_is_w ? {1'b0, w_alu_b[4:0]} : w_alu_b[5:0];

    // W-form right shifts pre-extend the low word so the low 32 result bits come out right.
    always_comb begin
        case (w_alu_op)
            ALU_ADD:  w_alu_raw = w_alu_a + w_alu_b;
            ALU_SUB:  w_alu_raw = w_alu_a - w_alu_b;
            ALU_SLL:  w_alu_raw = w_alu_a << w_shamt;
            ALU_SLT:  w_alu_raw = {{(ARCH_WIDTH-1){1'b0}}, ($signed(w_alu_a) < $signed(w_alu_b))};
            ALU_SLTU: w_alu_raw = {{(ARCH_WIDTH-1){1'b0}}, (w_alu_a < w_alu_b)};
            ALU_XOR:  w_alu_raw = w_alu_a ^ w_alu_b;
            ALU_SRL:  w_alu_raw = w_is_w ? ({{(ARCH_WIDTH-32){1'b0}}, w_alu_a[31:0]} >> w_shamt)
                                         : (w_alu_a >> w_shamt);
            ALU_SRA:  w_alu_raw = w_is_w ? ($signed({{(ARCH_WIDTH-32){w_alu_a[31]}}, w_alu_a[31:0]}) >>> w_shamt)
                                         : ($signed(w_alu_a) >>> w_shamt);
            ALU_OR:   w_alu_raw = w_alu_a | w_alu_b;
            ALU_AND:  w_alu_raw = w_alu_a & w_alu_b;
            default:  w_alu_raw = '0;
        endcase
    end

    assign w_alu_res = w_is_w ? {{(ARCH_WIDTH-32){w_alu_raw[31]}}, w_alu_raw[31:0]} : w_alu_raw;

    always_comb begin
        case (w_res_sel)
            RES_LINK:  w_wr_data = w_pc_plus4;
            RES_LUI:   w_wr_data = w_imm_u;
            RES_AUIPC: w_wr_data = r_pc + w_imm_u;
            default:   w_wr_data = w_alu_res;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
            for (int i = 0; i < 32; i++) r_regs[i] <= '0;
        end else begin
            r_pc <= w_next_pc;
            if (w_we && (w_rd != 5'd0)) r_regs[w_rd] <= w_wr_data;
        end
    end

endmodule

// File: tb/tb_core.sv
// Scoreboard bench for core: stimulus runs a mnemonic-level RV64I model and queues
// expected pc/register values; a monitor checks them after each retiring edge.
module tb_core;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] pc;
    logic [31:0] instruction = 32'h0;
    logic [4:0]  dbg_reg_addr = 5'd0;
    logic [63:0] dbg_reg_data;

    core dut (
        .clk(clk), .rst_n(rst_n), .pc(pc), .instruction(instruction),
        .dbg_reg_addr(dbg_reg_addr), .dbg_reg_data(dbg_reg_data)
    );

    always #5 clk = ~clk;

    typedef enum int {
        M_LUI, M_AUIPC, M_JAL, M_JALR, M_BEQ, M_BNE, M_BLT, M_BGE, M_BLTU, M_BGEU,
        M_ADDI, M_SLTI, M_SLTIU, M_XORI, M_ORI, M_ANDI, M_SLLI, M_SRLI, M_SRAI,
        M_ADD, M_SUB, M_SLL, M_SLT, M_SLTU, M_XOR, M_SRL, M_SRA, M_OR, M_AND,
        M_ADDIW, M_SLLIW, M_SRLIW, M_SRAIW, M_ADDW, M_SUBW, M_SLLW, M_SRLW, M_SRAW,
        M_LW, M_SD, M_FENCE, M_ECALL, M_ZERO, M_MUL, M_BAD_JALR, M_BAD_BR, M_LAST
    } mn_t;

    typedef struct {
        mn_t         mn;
        logic [63:0] exp_pc;
        logic [4:0]  reg_idx;
        logic [63:0] exp_val;
        bit          has_ref;
        logic [63:0] ref_val;
    } item_t;

    item_t       sb_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] m_pc = 64'h0;
    logic [63:0] m_x[32];

    task automatic check(input string what, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%h expected 0x%h", what, act, exp);
        end
    endtask

    function automatic logic [31:0] fld(input logic [6:0] f7, input logic [2:0] f3, input logic [6:0] op);
        return {f7, 10'b0, f3, 5'b0, op};
    endfunction

    function automatic logic [31:0] enc(input mn_t m, input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [63:0] imm);
        logic [31:0] it, st, rt, bt;
        it = {imm[11:0], rs1, 3'b000, rd, 7'b0};
        st = {6'b0, imm[5:0], rs1, 3'b000, rd, 7'b0};
        rt = {7'b0, rs2, rs1, 3'b000, rd, 7'b0};
        bt = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
        case (m)
            M_LUI:      return {imm[19:0], rd, 7'b0110111};
            M_AUIPC:    return {imm[19:0], rd, 7'b0010111};
            M_JAL:      return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
            M_JALR:     return it | fld(7'h00, 3'd0, 7'b1100111);
            M_BEQ:      return bt | fld(7'h00, 3'd0, 7'h0);
            M_BNE:      return bt | fld(7'h00, 3'd1, 7'h0);
            M_BLT:      return bt | fld(7'h00, 3'd4, 7'h0);
            M_BGE:      return bt | fld(7'h00, 3'd5, 7'h0);
            M_BLTU:     return bt | fld(7'h00, 3'd6, 7'h0);
            M_BGEU:     return bt | fld(7'h00, 3'd7, 7'h0);
            M_ADDI:     return it | fld(7'h00, 3'd0, 7'b0010011);
            M_SLTI:     return it | fld(7'h00, 3'd2, 7'b0010011);
            M_SLTIU:    return it | fld(7'h00, 3'd3, 7'b0010011);
            M_XORI:     return it | fld(7'h00, 3'd4, 7'b0010011);
            M_ORI:      return it | fld(7'h00, 3'd6, 7'b0010011);
            M_ANDI:     return it | fld(7'h00, 3'd7, 7'b0010011);
            M_SLLI:     return st | fld(7'h00, 3'd1, 7'b0010011);
            M_SRLI:     return st | fld(7'h00, 3'd5, 7'b0010011);
            M_SRAI:     return st | fld(7'h20, 3'd5, 7'b0010011);
            M_ADD:      return rt | fld(7'h00, 3'd0, 7'b0110011);
            M_SUB:      return rt | fld(7'h20, 3'd0, 7'b0110011);
            M_SLL:      return rt | fld(7'h00, 3'd1, 7'b0110011);
            M_SLT:      return rt | fld(7'h00, 3'd2, 7'b0110011);
            M_SLTU:     return rt | fld(7'h00, 3'd3, 7'b0110011);
            M_XOR:      return rt | fld(7'h00, 3'd4, 7'b0110011);
            M_SRL:      return rt | fld(7'h00, 3'd5, 7'b0110011);
            M_SRA:      return rt | fld(7'h20, 3'd5, 7'b0110011);
            M_OR:       return rt | fld(7'h00, 3'd6, 7'b0110011);
            M_AND:      return rt | fld(7'h00, 3'd7, 7'b0110011);
            M_ADDIW:    return it | fld(7'h00, 3'd0, 7'b0011011);
            M_SLLIW:    return st | fld(7'h00, 3'd1, 7'b0011011);
            M_SRLIW:    return st | fld(7'h00, 3'd5, 7'b0011011);
            M_SRAIW:    return st | fld(7'h20, 3'd5, 7'b0011011);
            M_ADDW:     return rt | fld(7'h00, 3'd0, 7'b0111011);
            M_SUBW:     return rt | fld(7'h20, 3'd0, 7'b0111011);
            M_SLLW:     return rt | fld(7'h00, 3'd1, 7'b0111011);
            M_SRLW:     return rt | fld(7'h00, 3'd5, 7'b0111011);
            M_SRAW:     return rt | fld(7'h20, 3'd5, 7'b0111011);
            M_LW:       return it | fld(7'h00, 3'd2, 7'b0000011);
            M_SD:       return {imm[11:5], rs2, rs1, 3'b011, imm[4:0], 7'b0100011};
            M_FENCE:    return 32'h0ff0000f;
            M_ECALL:    return 32'h00000073;
            M_MUL:      return rt | fld(7'h01, 3'd0, 7'b0110011);
            M_BAD_JALR: return it | fld(7'h00, 3'd1, 7'b1100111);
            M_BAD_BR:   return bt | fld(7'h00, 3'd2, 7'h0);
            default:    return 32'h0;
        endcase
    endfunction

    function automatic logic [63:0] sx32(input logic [31:0] w);
        return {{32{w[31]}}, w};
    endfunction

    // Architectural meaning of each mnemonic, in plain 64-bit arithmetic.
    function automatic void model_exec(input mn_t m, input logic [63:0] cur_pc, input logic [63:0] a,
                                       input logic [63:0] b, input logic [63:0] imm,
                                       output bit wr, output logic [63:0] val, output logic [63:0] npc);
        logic [63:0] uimm;
        uimm = {{32{imm[19]}}, imm[19:0], 12'b0};
        wr   = 1'b1;
        val  = 64'h0;
        npc  = cur_pc + 64'd4;
        case (m)
            M_LUI:   val = uimm;
            M_AUIPC: val = cur_pc + uimm;
            M_JAL:   begin val = cur_pc + 64'd4; npc = cur_pc + imm; end
            M_JALR:  begin val = cur_pc + 64'd4; npc = (a + imm) & ~64'd1; end
            M_BEQ:   begin wr = 1'b0; if (a == b) npc = cur_pc + imm; end
            M_BNE:   begin wr = 1'b0; if (a != b) npc = cur_pc + imm; end
            M_BLT:   begin wr = 1'b0; if ($signed(a) <  $signed(b)) npc = cur_pc + imm; end
            M_BGE:   begin wr = 1'b0; if ($signed(a) >= $signed(b)) npc = cur_pc + imm; end
            M_BLTU:  begin wr = 1'b0; if (a <  b) npc = cur_pc + imm; end
            M_BGEU:  begin wr = 1'b0; if (a >= b) npc = cur_pc + imm; end
            M_ADDI:  val = a + imm;
            M_SLTI:  val = ($signed(a) < $signed(imm)) ? 64'd1 : 64'd0;
            M_SLTIU: val = (a < imm) ? 64'd1 : 64'd0;
            M_XORI:  val = a ^ imm;
            M_ORI:   val = a | imm;
            M_ANDI:  val = a & imm;
            M_SLLI:  val = a << imm[5:0];
            M_SRLI:  val = a >> imm[5:0];
            M_SRAI:  val = $signed(a) >>> imm[5:0];
            M_ADD:   val = a + b;
            M_SUB:   val = a - b;
            M_SLL:   val = a << b[5:0];
            M_SLT:   val = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            M_SLTU:  val = (a < b) ? 64'd1 : 64'd0;
            M_XOR:   val = a ^ b;
            M_SRL:   val = a >> b[5:0];
            M_SRA:   val = $signed(a) >>> b[5:0];
            M_OR:    val = a | b;
            M_AND:   val = a & b;
            M_ADDIW: begin logic [31:0] w; w = a[31:0] + imm[31:0]; val = sx32(w); end
            M_SLLIW: begin logic [31:0] w; w = a[31:0] << imm[4:0]; val = sx32(w); end
            M_SRLIW: begin logic [31:0] w; w = a[31:0] >> imm[4:0]; val = sx32(w); end
            M_SRAIW: begin logic [31:0] w; w = $signed(a[31:0]) >>> imm[4:0]; val = sx32(w); end
            M_ADDW:  begin logic [31:0] w; w = a[31:0] + b[31:0]; val = sx32(w); end
            M_SUBW:  begin logic [31:0] w; w = a[31:0] - b[31:0]; val = sx32(w); end
            M_SLLW:  begin logic [31:0] w; w = a[31:0] << b[4:0]; val = sx32(w); end
            M_SRLW:  begin logic [31:0] w; w = a[31:0] >> b[4:0]; val = sx32(w); end
            M_SRAW:  begin logic [31:0] w; w = $signed(a[31:0]) >>> b[4:0]; val = sx32(w); end
            default: wr = 1'b0;
        endcase
    endfunction

    function automatic logic [63:0] gen_imm(input mn_t m);
        logic [31:0] r;
        r = $urandom;
        case (m)
            M_LUI, M_AUIPC:                      return {44'b0, r[19:0]};
            M_JAL:                               return {{43{r[20]}}, r[20:1], 1'b0};
            M_BEQ, M_BNE, M_BLT, M_BGE,
            M_BLTU, M_BGEU, M_BAD_BR:            return {{51{r[12]}}, r[12:1], 1'b0};
            M_SLLI, M_SRLI, M_SRAI:              return {58'b0, r[5:0]};
            M_SLLIW, M_SRLIW, M_SRAIW:           return {59'b0, r[4:0]};
            default:                             return {{52{r[11]}}, r[11:0]};
        endcase
    endfunction

    // Called at a falling edge: drives one instruction, predicts, queues, advances to the next falling edge.
    task automatic do_issue(input mn_t m, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [63:0] imm, input logic [4:0] chk, input bit has_ref,
                            input logic [63:0] ref_val);
        bit          wr;
        logic [63:0] val, npc;
        item_t       it;
        instruction = enc(m, rd, rs1, rs2, imm);
        model_exec(m, m_pc, m_x[rs1], m_x[rs2], imm, wr, val, npc);
        if (wr && rd != 5'd0) m_x[rd] = val;
        m_pc       = npc;
        it.mn      = m;
        it.exp_pc  = m_pc;
        it.reg_idx = chk;
        it.exp_val = m_x[chk];
        it.has_ref = has_ref;
        it.ref_val = ref_val;
        sb_q.push_back(it);
        @(negedge clk);
    endtask

    task automatic op(input mn_t m, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [63:0] imm);
        do_issue(m, rd, rs1, rs2, imm, rd, 1'b0, 64'h0);
    endtask

    task automatic op_ref(input mn_t m, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [63:0] imm, input logic [4:0] chk, input logic [63:0] ref_val);
        do_issue(m, rd, rs1, rs2, imm, chk, 1'b1, ref_val);
    endtask

    // Called at a falling edge; pc must drop before any clock edge arrives.
    task automatic apply_reset(input string tag);
        rst_n       = 1'b0;
        instruction = 32'h0;
        #1;
        check({tag, " async pc"}, pc, 64'h0);
        m_pc = 64'h0;
        for (int i = 0; i < 32; i++) m_x[i] = 64'h0;
        repeat (2) @(negedge clk);
        check({tag, " held pc"}, pc, 64'h0);
        rst_n = 1'b1;
    endtask

    initial begin : monitor
        item_t it;
        forever begin
            @(posedge clk);
            #2;
            if (sb_q.size() != 0) begin
                it = sb_q.pop_front();
                dbg_reg_addr = it.reg_idx;
                #1;
                check($sformatf("%s pc", it.mn.name()), pc, it.exp_pc);
                check($sformatf("%s x%0d", it.mn.name(), it.reg_idx), dbg_reg_data, it.exp_val);
                if (it.has_ref)
                    check($sformatf("%s x%0d plan", it.mn.name(), it.reg_idx), dbg_reg_data, it.ref_val);
            end
        end
    end

    initial begin : stimulus
        mn_t        m;
        logic [4:0] rd, rs1, rs2;
        for (int i = 0; i < 32; i++) m_x[i] = 64'h0;

        @(negedge clk);
        check("power-on reset pc", pc, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        op(M_ADDI, 5'd1, 5'd0, 5'd0, 64'd5);
        op(M_ADDI, 5'd2, 5'd0, 5'd0, -64'sd3);
        op(M_ADD,  5'd3, 5'd1, 5'd2, 64'h0);
        op(M_SUB,  5'd4, 5'd2, 5'd1, 64'h0);
        check("pc before mid-run reset", pc, 64'h10);
        apply_reset("mid-run reset");

        for (int i = 0; i < 32; i++) op_ref(M_ZERO, 5'd0, 5'd0, 5'd0, 64'h0, 5'(i), 64'h0);
        apply_reset("program reset");

        op(M_ADDI, 5'd1, 5'd0, 5'd0, 64'd5);
        op(M_ADDI, 5'd2, 5'd0, 5'd0, -64'sd3);
        op_ref(M_ADD,   5'd3, 5'd1, 5'd2, 64'h0, 5'd3, 64'd2);
        op_ref(M_SUB,   5'd4, 5'd2, 5'd1, 64'h0, 5'd4, 64'hFFFF_FFFF_FFFF_FFF8);
        op_ref(M_SLTU,  5'd5, 5'd1, 5'd2, 64'h0, 5'd5, 64'd1);
        op_ref(M_SRA,   5'd6, 5'd2, 5'd1, 64'h0, 5'd6, 64'hFFFF_FFFF_FFFF_FFFF);
        op_ref(M_AUIPC, 5'd8, 5'd0, 5'd0, 64'h1, 5'd8, 64'h1018);
        op_ref(M_LUI,   5'd7, 5'd0, 5'd0, 64'h80000, 5'd7, 64'hFFFF_FFFF_8000_0000);
        op(M_BEQ, 5'd0, 5'd0, 5'd0, 64'd12);
        op(M_BNE, 5'd0, 5'd0, 5'd0, 64'd12);
        op_ref(M_JAL,   5'd1, 5'd0, 5'd0, -64'sd16, 5'd1, 64'h34);
        check("pc after JAL", pc, 64'h20);
        op_ref(M_JALR,  5'd2, 5'd1, 5'd0, 64'd3, 5'd2, 64'h24);
        check("pc after JALR", pc, 64'h36);
        op_ref(M_ADDI,  5'd0, 5'd0, 5'd0, 64'd9, 5'd0, 64'h0);
        op(M_LUI, 5'd1, 5'd0, 5'd0, 64'h80000);
        op_ref(M_ADDIW, 5'd1, 5'd1, 5'd0, -64'sd1, 5'd1, 64'h7FFF_FFFF);
        op_ref(M_ADDIW, 5'd9, 5'd1, 5'd0, 64'd1, 5'd9, 64'hFFFF_FFFF_8000_0000);
        op_ref(M_SLLIW, 5'd10, 5'd1, 5'd0, 64'd4, 5'd10, 64'hFFFF_FFFF_FFFF_FFF0);
        op_ref(M_LW,    5'd1, 5'd0, 5'd0, 64'h0, 5'd1, 64'h7FFF_FFFF);
        op_ref(M_ZERO,  5'd0, 5'd0, 5'd0, 64'h0, 5'd1, 64'h7FFF_FFFF);
        op(M_JALR, 5'd3, 5'd3, 5'd0, 64'h40);

        for (int n = 0; n < 1500; n++) begin
            m   = mn_t'($urandom_range(0, int'(M_LAST) - 1));
            rd  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            rs1 = 5'($urandom_range(0, 7));
            rs2 = ($urandom_range(0, 7) == 0) ? rs1 : 5'($urandom_range(0, 7));
            op(m, rd, rs1, rs2, gen_imm(m));
        end

        repeat (3) @(negedge clk);
        check("scoreboard drained", 64'(sb_q.size()), 64'h0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
